// File: rtl/port_read_scheduler.sv
// ============================================================================
// port_read_scheduler
//
// Packet-granular round-robin scheduler that drains three first-word-fall-
// through port FIFOs onto one shared 8-bit output link. A grant is taken only
// in IDLE and held for a whole packet (SRC, DST, SIZE, 1..8 data bytes, CRC).
// Downstream backpressure simply holds the current byte. A granted FIFO that
// stays empty for STALL_MAX consecutive cycles causes the packet to be
// abandoned with a one-cycle pkt_abort pulse.
//
// Ports
//   clk1                 system clock, all logic on the rising edge
//   rst                  synchronous reset, active high
//   rempty_port_1..3     FIFO n empty
//   rdata_port_1..3      FIFO n head byte (valid when not empty)
//   rinc_port_1..3       pop FIFO n head at this clock edge
//   out_ready            downstream accepts the byte this cycle
//   out_valid            out_data valid
//   out_data             output byte, 8'h00 when out_valid is low
//   out_sop / out_eop    current byte is SRC / CRC
//   grant_port           0 = none, 1..3 = granted port
//   pkt_abort            one-cycle pulse when a packet is abandoned
// ============================================================================
module port_read_scheduler #(
    parameter logic [7:0] STALL_MAX = 8'd255
) (
    input  logic       clk1,
    input  logic       rst,
    input  logic       rempty_port_1,
    input  logic       rempty_port_2,
    input  logic       rempty_port_3,
    input  logic [7:0] rdata_port_1,
    input  logic [7:0] rdata_port_2,
    input  logic [7:0] rdata_port_3,
    output logic       rinc_port_1,
    output logic       rinc_port_2,
    output logic       rinc_port_3,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_sop,
    output logic       out_eop,
    output logic [1:0] grant_port,
    output logic       pkt_abort
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SRC  = 3'd1,
        ST_DST  = 3'd2,
        ST_SIZE = 3'd3,
        ST_DATA = 3'd4,
        ST_CRC  = 3'd5
    } state_t;

    state_t     r_state, w_state_next;
    logic [1:0] r_grant, w_grant_next;
    logic [1:0] r_last_grant, w_last_grant_next;
    logic [2:0] r_data_cnt, w_data_cnt_next;
    logic [7:0] r_stall_cnt, w_stall_cnt_next;
    logic       r_pkt_abort, w_abort;

    logic [2:0] w_empty_vec;
    logic [7:0] w_rdata_arr [0:2];
    logic [2:0] w_rinc_vec;
    logic       w_g_empty;
    logic [7:0] w_g_data;
    logic       w_valid;
    logic       w_transfer;
    logic [1:0] w_order [0:2];
    logic [1:0] w_pick;

    assign w_empty_vec    = {rempty_port_3, rempty_port_2, rempty_port_1};
    assign w_rdata_arr[0] = rdata_port_1;
    assign w_rdata_arr[1] = rdata_port_2;
    assign w_rdata_arr[2] = rdata_port_3;

    // Head of the granted FIFO; with no grant it looks like an empty FIFO.
    always_comb begin
        w_g_empty = 1'b1;
        w_g_data  = 8'h00;
        for (int i = 0; i < 3; i++) begin
            if (r_grant == 2'(i + 1)) begin
                w_g_empty = w_empty_vec[i];
                w_g_data  = w_rdata_arr[i];
            end
        end
    end

    assign w_valid = (r_state != ST_IDLE) && !w_g_empty;
    // A byte is never popped in the reset cycle so the FIFO keeps it.
    assign w_transfer = w_valid && out_ready && !rst;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rinc
            assign w_rinc_vec[gi] = w_transfer && (r_grant == 2'(gi + 1));
        end
    endgenerate

    assign rinc_port_1 = w_rinc_vec[0];
    assign rinc_port_2 = w_rinc_vec[1];
    assign rinc_port_3 = w_rinc_vec[2];

    assign out_valid  = w_valid;
    assign out_data   = w_valid ? w_g_data : 8'h00;
    assign out_sop    = w_valid && (r_state == ST_SRC);
    assign out_eop    = w_valid && (r_state == ST_CRC);
    assign grant_port = r_grant;
    assign pkt_abort  = r_pkt_abort;

    // Round-robin search order, starting just after the last granted port.
    always_comb begin
        case (r_last_grant)
            2'd1: begin
                w_order[0] = 2'd2; w_order[1] = 2'd3; w_order[2] = 2'd1;
            end
            2'd2: begin
                w_order[0] = 2'd3; w_order[1] = 2'd1; w_order[2] = 2'd2;
            end
            default: begin
                w_order[0] = 2'd1; w_order[1] = 2'd2; w_order[2] = 2'd3;
            end
        endcase
    end

    // Scan from the lowest priority upward so the first candidate wins last.
    always_comb begin
        w_pick = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            if (!w_empty_vec[2'(w_order[k] - 2'd1)]) begin
                w_pick = w_order[k];
            end
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_grant_next      = r_grant;
        w_last_grant_next = r_last_grant;
        w_data_cnt_next   = r_data_cnt;
        w_stall_cnt_next  = r_stall_cnt;
        w_abort           = 1'b0;

        if (r_state == ST_IDLE) begin
            w_stall_cnt_next = 8'd0;
            if (w_pick != 2'd0) begin
                w_grant_next      = w_pick;
                w_last_grant_next = w_pick;
                w_state_next      = ST_SRC;
            end
        end else if (w_transfer) begin
            w_stall_cnt_next = 8'd0;
            case (r_state)
                ST_SRC:  w_state_next = ST_DST;
                ST_DST:  w_state_next = ST_SIZE;
                ST_SIZE: begin
                    w_data_cnt_next = w_g_data[2:0];
                    w_state_next    = ST_DATA;
                end
                ST_DATA: begin
                    if (r_data_cnt == 3'd0) begin
                        w_state_next = ST_CRC;
                    end else begin
                        w_data_cnt_next = r_data_cnt - 3'd1;
                    end
                end
                ST_CRC: begin
                    w_state_next = ST_IDLE;
                    w_grant_next = 2'd0;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end else if (w_g_empty) begin
            // Underrun. Backpressure with data present leaves the count alone.
            if (r_stall_cnt == STALL_MAX - 8'd1) begin
                w_abort          = 1'b1;
                w_state_next     = ST_IDLE;
                w_grant_next     = 2'd0;
                w_stall_cnt_next = 8'd0;
            end else begin
                w_stall_cnt_next = r_stall_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= 2'd0;
            r_last_grant <= 2'd3;
            r_data_cnt   <= 3'd0;
            r_stall_cnt  <= 8'd0;
            r_pkt_abort  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_grant      <= w_grant_next;
            r_last_grant <= w_last_grant_next;
            r_data_cnt   <= w_data_cnt_next;
            r_stall_cnt  <= w_stall_cnt_next;
            r_pkt_abort  <= w_abort;
        end
    end

endmodule

// File: tb/tb_port_read_scheduler.sv
module tb_port_read_scheduler;

    localparam logic [7:0] STALL_MAX = 8'd4;

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic       rst;
    logic       out_ready;
    logic       rempty_v [1:3];
    logic [7:0] rdata_v  [1:3];
    logic       rinc_port_1, rinc_port_2, rinc_port_3;
    logic       out_valid, out_sop, out_eop, pkt_abort;
    logic [7:0] out_data;
    logic [1:0] grant_port;
    logic       w_rinc [1:3];

    port_read_scheduler #(.STALL_MAX(STALL_MAX)) dut (
        .clk1          (clk1),
        .rst           (rst),
        .rempty_port_1 (rempty_v[1]),
        .rempty_port_2 (rempty_v[2]),
        .rempty_port_3 (rempty_v[3]),
        .rdata_port_1  (rdata_v[1]),
        .rdata_port_2  (rdata_v[2]),
        .rdata_port_3  (rdata_v[3]),
        .rinc_port_1   (rinc_port_1),
        .rinc_port_2   (rinc_port_2),
        .rinc_port_3   (rinc_port_3),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_sop       (out_sop),
        .out_eop       (out_eop),
        .grant_port    (grant_port),
        .pkt_abort     (pkt_abort)
    );

    assign w_rinc[1] = rinc_port_1;
    assign w_rinc[2] = rinc_port_2;
    assign w_rinc[3] = rinc_port_3;

    int total = 0;
    int bad   = 0;

    // FWFT FIFO models: bytes pushed at a negedge become visible after the
    // next rising edge; a pop happens on a rising edge with rinc high.
    logic [7:0] pend [1:3][0:63];
    int         pw [1:3];
    int         pr [1:3];

    always @(posedge clk1) begin
        for (int p = 1; p <= 3; p++) begin
            int np;
            np = pr[p] + (w_rinc[p] ? 1 : 0);
            pr[p]       <= np;
            rempty_v[p] <= (np == pw[p]);
            rdata_v[p]  <= pend[p][np % 64];
        end
    end

    // Transfer log.
    logic [7:0] log_data [$];
    logic       log_sop [$];
    logic       log_eop [$];
    logic [1:0] log_grant [$];
    int         log_cyc [$];
    int         cyc = 0;
    int         eop_cnt = 0;
    int         rinc_cnt [1:3];

    always @(posedge clk1) begin
        cyc <= cyc + 1;
        if (!rst && out_valid && out_ready) begin
            log_data.push_back(out_data);
            log_sop.push_back(out_sop);
            log_eop.push_back(out_eop);
            log_grant.push_back(grant_port);
            log_cyc.push_back(cyc);
            if (out_eop) eop_cnt <= eop_cnt + 1;
        end
        if (rinc_port_1) rinc_cnt[1] <= rinc_cnt[1] + 1;
        if (rinc_port_2) rinc_cnt[2] <= rinc_cnt[2] + 1;
        if (rinc_port_3) rinc_cnt[3] <= rinc_cnt[3] + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int p, input logic [7:0] b);
        pend[p][pw[p]] = b;
        pw[p] = pw[p] + 1;
    endtask

    task automatic wait_eops(input int target, input string tag);
        int k;
        k = 0;
        while (eop_cnt < target && k < 300) begin
            @(negedge clk1);
            k++;
        end
        chk(tag, 32'(eop_cnt >= target), 32'd1);
    endtask

    task automatic wait_show(input logic [1:0] g, input logic [7:0] d, input string tag);
        int  k;
        logic found;
        k = 0;
        found = 1'b0;
        while (!found && k < 50) begin
            @(negedge clk1);
            k++;
            if (out_valid && grant_port == g && out_data == d) found = 1'b1;
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_grant"}, 32'(grant_port), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"},  32'(out_data), 32'd0);
        chk({tag, "_sop"},   32'(out_sop), 32'd0);
        chk({tag, "_eop"},   32'(out_eop), 32'd0);
        chk({tag, "_rinc"},  32'({rinc_port_1, rinc_port_2, rinc_port_3}), 32'd0);
        chk({tag, "_abort"}, 32'(pkt_abort), 32'd0);
    endtask

    function automatic logic [7:0] pkt_byte(input int p, input int k, input int i);
        logic [7:0] pb, kb;
        pb = 8'(p);
        kb = 8'(k);
        case (i)
            0:       return 8'h10 * pb + kb;
            1:       return 8'h80 + pb;
            2:       return 8'h00;
            3:       return 8'hA0 + (kb << 4) + pb;
            default: return 8'hC0 + (kb << 4) + pb;
        endcase
    endfunction

    logic [7:0] t1 [0:7] = '{8'h01, 8'h85, 8'h03, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h5C};
    logic [7:0] t4 [0:7] = '{8'h21, 8'h22, 8'h03, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hC3};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, eb, b0, p, k;
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk1);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk1);

        // Single packet on port 2.
        b0 = rinc_cnt[2];
        for (int i = 0; i < 8; i++) push(2, t1[i]);
        @(negedge clk1);
        chk("t1_pre_grant", 32'(grant_port), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk1);
            chk($sformatf("t1_grant%0d", i), 32'(grant_port), 32'd2);
            chk($sformatf("t1_byte%0d", i), 32'(out_data), 32'(t1[i]));
            chk($sformatf("t1_sop%0d", i), 32'(out_sop), 32'(i == 0));
            chk($sformatf("t1_eop%0d", i), 32'(out_eop), 32'(i == 7));
        end
        @(negedge clk1);
        chk("t1_idle_grant", 32'(grant_port), 32'd0);
        chk("t1_idle_valid", 32'(out_valid), 32'd0);
        chk("t1_rinc_count", 32'(rinc_cnt[2] - b0), 32'd8);

        // Two minimum packets on every port, round-robin.
        rst = 1'b1;
        @(negedge clk1);
        rst = 1'b0;
        base = log_data.size();
        eb = eop_cnt;
        for (int kk = 0; kk < 2; kk++)
            for (int pp = 1; pp <= 3; pp++)
                for (int i = 0; i < 5; i++) push(pp, pkt_byte(pp, kk, i));
        wait_eops(eb + 6, "t2_done");
        for (int j = 0; j < 6; j++) begin
            p = (j % 3) + 1;
            k = j / 3;
            chk($sformatf("t2_grant%0d", j), 32'(log_grant[base + 5 * j]), 32'(p));
            for (int i = 0; i < 5; i++)
                chk($sformatf("t2_pkt%0d_byte%0d", j, i), 32'(log_data[base + 5 * j + i]),
                    32'(pkt_byte(p, k, i)));
            if (j > 0)
                chk($sformatf("t2_gap%0d", j),
                    32'(log_cyc[base + 5 * j] - log_cyc[base + 5 * (j - 1)]), 32'd6);
        end

        // SIZE FF gives 8 data bytes, 12 bytes total.
        base = log_data.size();
        eb = eop_cnt;
        push(1, 8'h11); push(1, 8'h22); push(1, 8'hFF);
        for (int i = 0; i < 8; i++) push(1, 8'h60 + 8'(i));
        push(1, 8'h99);
        wait_eops(eb + 1, "t3_done");
        chk("t3_len", 32'(log_data.size() - base), 32'd12);
        chk("t3_grant", 32'(log_grant[base]), 32'd1);
        chk("t3_sop", 32'(log_sop[base]), 32'd1);
        chk("t3_eop_early", 32'(log_eop[base + 10]), 32'd0);
        chk("t3_eop_last", 32'(log_eop[base + 11]), 32'd1);
        chk("t3_crc", 32'(log_data[base + 11]), 32'h99);

        // Backpressure for five cycles inside DATA.
        base = log_data.size();
        eb = eop_cnt;
        for (int i = 0; i < 8; i++) push(2, t4[i]);
        wait_show(2'd2, 8'hB1, "t4_find_b1");
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("t4_hold_data%0d", i), 32'(out_data), 32'hB1);
            chk($sformatf("t4_hold_valid%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("t4_hold_rinc%0d", i), 32'(rinc_port_2), 32'd0);
            chk($sformatf("t4_hold_abort%0d", i), 32'(pkt_abort), 32'd0);
            @(negedge clk1);
        end
        out_ready = 1'b1;
        wait_eops(eb + 1, "t4_done");
        chk("t4_len", 32'(log_data.size() - base), 32'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t4_byte%0d", i), 32'(log_data[base + i]), 32'(t4[i]));

        // Underrun on port 3 after SIZE.
        push(3, 8'h31); push(3, 8'h32); push(3, 8'h05);
        wait_show(2'd3, 8'h31, "t5_src");
        @(negedge clk1);
        chk("t5_dst", 32'(out_data), 32'h32);
        @(negedge clk1);
        chk("t5_size", 32'(out_data), 32'h05);
        @(negedge clk1);
        chk("t5_stall_valid", 32'(out_valid), 32'd0);
        chk("t5_stall1_grant", 32'(grant_port), 32'd3);
        chk("t5_stall1_abort", 32'(pkt_abort), 32'd0);
        base = log_data.size();
        eb = eop_cnt;
        push(1, 8'h51); push(1, 8'h52); push(1, 8'h00); push(1, 8'h5D); push(1, 8'h5E);
        push(2, 8'h61); push(2, 8'h62); push(2, 8'h00); push(2, 8'h6D); push(2, 8'h6E);
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk1);
            chk($sformatf("t5_stall%0d_abort", i), 32'(pkt_abort), 32'd0);
            chk($sformatf("t5_stall%0d_grant", i), 32'(grant_port), 32'd3);
        end
        @(negedge clk1);
        chk("t5_abort_pulse", 32'(pkt_abort), 32'd1);
        chk("t5_abort_grant", 32'(grant_port), 32'd0);
        @(negedge clk1);
        chk("t5_abort_end", 32'(pkt_abort), 32'd0);
        chk("t5_next_grant", 32'(grant_port), 32'd1);
        wait_eops(eb + 2, "t5_done");
        chk("t5_first_src", 32'(log_data[base]), 32'h51);
        chk("t5_second_grant", 32'(log_grant[base + 5]), 32'd2);
        chk("t5_second_src", 32'(log_data[base + 5]), 32'h61);

        // Reset while a DATA byte is on the link.
        push(2, 8'h41); push(2, 8'h42); push(2, 8'h01);
        push(2, 8'hD0); push(2, 8'hD1); push(2, 8'hE1);
        wait_show(2'd2, 8'hD0, "t6_find_data");
        rst = 1'b1;
        push(1, 8'h71); push(1, 8'h72); push(1, 8'h00); push(1, 8'h7D); push(1, 8'h7E);
        #1;
        chk("t6_no_rinc_in_rst", 32'(rinc_port_2), 32'd0);
        @(negedge clk1);
        chk_reset_outputs("t6_after_rst");
        chk("t6_fifo_kept_empty", 32'(rempty_v[2]), 32'd0);
        chk("t6_fifo_kept_head", 32'(rdata_v[2]), 32'hD0);
        rst = 1'b0;
        @(negedge clk1);
        chk("t6_first_grant", 32'(grant_port), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/port_read_scheduler.md
# port_read_scheduler

Round-robin, packet-granular scheduler that drains the three per-port write FIFOs fed by the packet receiver onto one shared 8-bit output link. It arbitrates only at packet boundaries and holds a grant for a whole packet: SRC, DST, SIZE, data, CRC. It honours downstream backpressure and aborts a packet whose source FIFO underruns for too long. It sits between the port FIFOs' read side and the router output serializer.

## Interface
- STALL_MAX, 8'd255: consecutive FIFO-empty cycles tolerated mid-packet before abort; legal range 1..255.
- clk1  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- rempty_port_1/2/3  input  1  FIFO n empty.
- rdata_port_1/2/3  input  8  FIFO n head byte (first-word-fall-through), valid when rempty_port_n=0.
- rinc_port_1/2/3  output  1  pops FIFO n head at this clock edge.
- out_ready  input  1  downstream accepts the byte this cycle.
- out_valid  output  1  out_data valid.
- out_data  output  8  output byte; 8'h00 when out_valid=0.
- out_sop  output  1  current byte is SRC (first byte).
- out_eop  output  1  current byte is CRC (last byte).
- grant_port  output  2  granted port: 0 = none, 1..3 = port n.
- pkt_abort  output  1  one-cycle pulse: granted packet abandoned on underrun.

## Operation
- Packet format: SRC, DST, SIZE, N data bytes, CRC.
  - N = SIZE[2:0]+1 (1..8); SIZE[7:3] ignored.
  - Total length = N+4 bytes.
- Transfer happens when out_valid && out_ready.
- States:
  - IDLE: grant_port=0, out_valid=0.
  - SRC, DST, SIZE, DATA, CRC: one state per packet field.
- Registers: last_grant (2 bit, reset 3), data_cnt (3 bit), stall_cnt (8 bit).
- IDLE arbitration:
  - Candidates are ports with rempty=0.
  - Search order starts at last_grant+1 and wraps 3→1 (e.g. last_grant=1 gives order 2,3,1).
  - The winner is registered into grant_port and last_grant; next state is SRC.
  - No candidate: stay in IDLE.
- Granted (non-IDLE) state:
  - out_valid = ~rempty of the granted port.
  - out_data = rdata of the granted port.
  - rinc of the granted port = transfer (combinational); rinc of other ports = 0.
- Transitions, taken only on a transfer:
  - SRC→DST, DST→SIZE.
  - SIZE→DATA, loading data_cnt ← out_data[2:0].
  - DATA: if data_cnt=0 go to CRC, else data_cnt−1 and stay in DATA.
  - CRC→IDLE, with grant_port ← 0.
- out_sop = out_valid in SRC; out_eop = out_valid in CRC.
- Stall handling:
  - A stalled cycle is a non-IDLE cycle with granted-port rempty=1.
  - out_ready=0 with data present is backpressure, not a stall.
  - stall_cnt increments on each stalled cycle.
  - stall_cnt clears on any transfer, on entry to SRC, and in IDLE.
  - On a stalled cycle with stall_cnt = STALL_MAX−1:
    - next state is IDLE and grant_port ← 0;
    - pkt_abort ← 1 for exactly one cycle;
    - last_grant keeps the aborted port, so the next search starts after it.
- Bytes already popped are not replayed. The abandoned remainder stays in the FIFO; the scheduler treats the next byte it arbitrates as SRC.

## Timing
- Reset values: state IDLE, grant_port 0, out_valid 0, out_data 8'h00, out_sop 0, out_eop 0, rinc_port_* 0, pkt_abort 0, last_grant 3, data_cnt 0, stall_cnt 0.
- rst during a packet: next cycle is IDLE with all outputs at reset values.
  - No rinc in the reset cycle.
  - The FIFO keeps the unsent bytes.
- Arbitration latency: FIFO going non-empty in IDLE gives grant_port and out_valid/out_sop in the next cycle.
- Packet-to-packet gap: exactly one IDLE cycle after the CRC transfer.
- Throughput: one byte per cycle while out_ready=1 and the FIFO is non-empty. Minimum packet occupancy is N+4 transfer cycles plus 1 IDLE cycle.
- Backpressure: while out_ready=0, out_data/out_valid hold with no rinc and stall_cnt unchanged.
- Simultaneous stall-limit and rst: rst wins and pkt_abort stays 0.
- STALL_MAX=1: abort occurs on the cycle after the first stalled cycle.

## Test plan
- Single packet, port 2 (SRC 01, DST 85, SIZE 03, data A0 A1 A2 A3, CRC 5C), out_ready=1:
  - grant_port=2 one cycle after non-empty;
  - 8 consecutive bytes in order;
  - sop on 01, eop on 5C;
  - 8 rinc_port_2 pulses;
  - IDLE one cycle after CRC.
- Reset, then all three FIFOs each loaded with two 5-byte packets (SIZE 00):
  - grant sequence 1,2,3,1,2,3;
  - one idle cycle between packets.
- Port 1 packet with SIZE FF:
  - 12 bytes output, with eop on the 12th.
- Backpressure: out_ready=0 for 5 cycles during DATA:
  - out_data held, no rinc, no pkt_abort;
  - resumes with no byte lost or duplicated.
- Underrun: STALL_MAX=4, port 3 FIFO empties after SIZE:
  - pkt_abort high on the 5th cycle after the empty begins, grant_port=0 at the same cycle;
  - with port 1 then non-empty, port 1 is granted next.
- rst asserted on the DATA byte:
  - next cycle all outputs at reset values;
  - after release, first grant goes to port 1 if non-empty.
